// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/state types and default operand width for the board ALU controller.
package alu_ctrl_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_adder.sv
// W-bit ripple adder with carry-out and signed overflow; combinational, no backpressure.
module alu_adder
  import alu_ctrl_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  assign overflow    = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);

endmodule

// File: rtl/alu_ctrl.sv
// One-at-a-time ALU sequencer: non-MUL ops answer 1 cycle after accept, MUL W+1 cycles (ALU_CTRL_MUL_EN).
// Result and flags are held in DONE until out_ready; in_ready is high only in IDLE.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           cout,
  output logic           overflow,
  output logic           zero,
  output logic           err
);

  alu_state_e     state_q, state_d;
  alu_op_e        op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*W-1:0] result_q, result_d;
  logic           out_valid_q, out_valid_d;
  logic           cout_q, cout_d, overflow_q, overflow_d;
  logic           zero_q, zero_d, err_q, err_d;
`ifdef ALU_CTRL_MUL_EN
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] p_q, p_d;
`endif

  logic [W-1:0] add_x, add_y, add_sum;
  logic         add_cin, add_cout, add_ovf;

  // Single shared adder: subtract-style ops feed ~b with carry-in, MUL feeds the partial product.
  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_cin = 1'b0;
    if (op_q != OP_ADD) begin
      add_y   = ~b_q;
      add_cin = 1'b1;
    end
`ifdef ALU_CTRL_MUL_EN
    if (state_q == MUL) begin
      add_x   = p_q[2*W-1:W];
      add_y   = b_q;
      add_cin = 1'b0;
    end
`endif
  end

  alu_adder #(.W(W)) u_adder (
    .x        (add_x),
    .y        (add_y),
    .cin      (add_cin),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    err_d       = err_q;
`ifdef ALU_CTRL_MUL_EN
    cnt_d       = cnt_q;
    p_d         = p_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = alu_op_e'(op);
          a_d     = a;
          b_d     = b;
          state_d = EXEC;
`ifdef ALU_CTRL_MUL_EN
          if (alu_op_e'(op) == OP_MUL) begin
            state_d = MUL;
            cnt_d   = '0;
            p_d     = {{W{1'b0}}, a};
          end
`endif
        end
      end
      EXEC: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = '0;
        cout_d      = 1'b0;
        overflow_d  = 1'b0;
        err_d       = 1'b0;
        case (op_q)
          OP_ADD, OP_SUB: begin
            result_d[W-1:0] = add_sum;
            cout_d          = add_cout;
            overflow_d      = add_ovf;
          end
          OP_AND:  result_d[W-1:0] = a_q & b_q;
          OP_OR:   result_d[W-1:0] = a_q | b_q;
          OP_XOR:  result_d[W-1:0] = a_q ^ b_q;
          OP_SLT:  result_d[0]     = add_sum[W-1] ^ add_ovf;
          OP_EQ:   result_d[0]     = (add_sum == '0);
          // Only an unsupported MUL can land here.
          default: err_d = 1'b1;
        endcase
        zero_d = (result_d == '0);
      end
`ifdef ALU_CTRL_MUL_EN
      MUL: begin
        if (cnt_q == CW'(W)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = p_q;
          zero_d      = (p_q == '0);
          cout_d      = 1'b0;
          overflow_d  = 1'b0;
          err_d       = 1'b0;
        end else begin
          p_d   = p_q[0] ? {add_cout, add_sum, p_q[W-1:1]}
                         : {1'b0, p_q[2*W-1:W], p_q[W-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      cnt_q       <= '0;
      p_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
`ifdef ALU_CTRL_MUL_EN
      cnt_q       <= cnt_d;
      p_q         <= p_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing controller for the board ALU. It accepts one operation at a time over a valid/ready handshake and runs it on a single shared W-bit adder, multi-cycle for multiply. It returns an 8-bit result plus flags over a second valid/ready handshake. It sits between the switch/key input logic and the display driver.

## Interface
- `W`, default 4: operand width; the result is 2W bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  controller can accept; equals `state==IDLE`.
- `op`  in  3  opcode:
  - 000 ADD, 001 SUB, 010 MUL, 011 AND
  - 100 OR, 101 XOR, 110 SLT (signed), 111 EQ
- `a`, `b`  in  W  operands; two's complement for ADD/SUB/SLT, unsigned for MUL.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  2W  result; upper W bits are zero except for MUL.
- `cout`  out  1  adder carry (ADD/SUB only, else 0).
- `overflow`  out  1  signed overflow (ADD/SUB only, else 0).
- `zero`  out  1  `result==0`.
- `err`  out  1  illegal or unsupported op.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: on `in_valid && in_ready`, latch `op`, `a`, `b`.
  - MUL goes to MUL with iteration counter 0 and product register P = {W'0, a}.
  - All other ops go to EXEC.
- EXEC (one cycle): compute through the shared adder and register outputs, then go to DONE.
  - ADD: `a+b+0`.
  - SUB: `a+~b+1`. `cout=1` means no borrow.
  - `overflow = (x[W-1]==y[W-1]) && (sum[W-1]!=x[W-1])`, where x, y are the adder inputs.
  - SLT: result = `sum[W-1]^overflow` of SUB.
  - EQ: result = (SUB sum==0).
  - AND/OR/XOR: bitwise result; they do not use the adder.
- MUL, each cycle:
  - If `P[0]`: {c,hi} = P[2W-1:W] + b, otherwise {c,hi} = {0, P[2W-1:W]}.
  - P ← {c, hi, P[W-1:1]}.
  - Counter increments; after iteration W-1, latch result=P and go to DONE.
- DONE: `out_valid=1`. `result`/flags are held stable until `out_ready`, then go to IDLE.
- `in_valid` is ignored outside IDLE. Opcodes are not queued.
- `rst` asserted in any state, including mid-MUL:
  - Immediately returns to IDLE and clears P, counter, `result`, and all flags.
  - `out_valid=0`. The in-flight op is discarded.
- Reset values: `out_valid=0`, `result=0`, `cout=0`, `overflow=0`, `zero=0`, `err=0`.
- `in_ready=1` in IDLE, but no handshake is taken while `rst` is high.

## Timing
- Accept at edge k:
  - Non-MUL: result registered at edge k+1; `out_valid` high from k+1.
  - MUL: iterations at edges k+1..k+W; `out_valid` high from edge k+W+1 (W+1 cycles total).
- Consumption at edge j (`out_valid && out_ready`): IDLE from j, so `in_ready=1` in the cycle after j.
- Maximum throughput: one non-MUL op per 3 cycles with `out_ready` tied high.
- All outputs are registered except `in_ready`, which is decoded from state.

## Configuration
- `ALU_CTRL_MUL_EN` defined: MUL is supported as described; `err=0` for all opcodes.
- `ALU_CTRL_MUL_EN` undefined:
  - The MUL state, P register and counter are removed.
  - Op 010 goes through EXEC with result=0, `err=1`, `zero=1`, and latency 1.

## Structure
- Package `alu_ctrl_pkg` holds:
  - opcode enum `alu_op_e`
  - state enum `alu_state_e`
  - default width constant `ALU_W=4`
- Sub-module `alu_adder` (W-bit):
  - Inputs `x`, `y`, `cin`; outputs `sum`, `cout`, `overflow`.
  - Instantiated once and shared by ADD/SUB/SLT/EQ/MUL through an input mux driven by state and op.

## Test plan
- ADD a=7, b=1 → result 0x08, `cout=0`, `overflow=1`, `zero=0`; `out_valid` one cycle after accept.
- SUB a=3, b=5 → result 0x0E, `cout=0`, `overflow=0`. SUB a=5, b=5 → result 0x00, `zero=1`, `cout=1`.
- MUL a=15, b=15 → result 0xE1, `out_valid` 5 cycles after accept. MUL a=0, b=9 → 0x00, `zero=1`.
- SLT a=8 (−8), b=7 → result 1. EQ a=9, b=9 → 1. EQ a=9, b=8 → 0.
- Backpressure: ADD 2+2 with `out_ready` low for 3 cycles → result 0x04 held, `in_ready=0`, and a new `in_valid` is ignored. Raise `out_ready` → IDLE next cycle.
- Assert `rst` after MUL iteration 2 → `out_valid=0`, `result=0` immediately. After release, XOR a=0xA, b=0x5 → 0x0F.
- Without the macro: MUL 3×3 → result 0, `err=1`, latency 1.
